// File: rtl/base_mem_rdstream.sv
// base_mem_rdstream
//
// Read-side sequencer for a simple dual-port RAM with a registered read port
// (1-cycle read latency). Accepts a burst command (start address, beat count),
// issues one RAM read per cycle while buffer space allows, and presents the
// returned words as a valid/ready stream with a last-beat marker. A 2-entry
// FIFO absorbs the RAM latency so a burst streams at 1 beat/cycle under
// continuous ready and no word is lost under backpressure.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   i_v / i_r         command valid / ready (ready only when idle)
//   i_addr, i_cnt     burst start address, beat count (0 = empty burst)
//   o_rd_re, o_rd_ra  RAM read enable / address
//   i_rd_rd           RAM read data, valid the cycle after o_rd_re
//   o_v / o_r         output beat valid / ready
//   o_d, o_last       output data, final-beat marker (qualified by o_v)
//   o_idle            no command active, nothing in flight or buffered

module base_mem_rdstream #(
    parameter int unsigned width      = 1,
    parameter int unsigned addr_width = 1,
    parameter int unsigned cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_v,
    output logic                  i_r,
    input  logic [addr_width-1:0] i_addr,
    input  logic [cnt_width-1:0]  i_cnt,
    output logic                  o_rd_re,
    output logic [addr_width-1:0] o_rd_ra,
    input  logic [width-1:0]      i_rd_rd,
    output logic                  o_v,
    input  logic                  o_r,
    output logic [width-1:0]      o_d,
    output logic                  o_last,
    output logic                  o_idle
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                state_q;
    logic [addr_width-1:0] addr_q;
    logic [cnt_width-1:0]  issue_rem_q;
    logic [cnt_width-1:0]  deliver_rem_q;
    logic                  inflight_q;
    logic [width-1:0]      buf_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            buf_cnt_q;

    logic                  accept;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ_after_pop;

    always_comb begin
        accept = i_v & i_r;
        pop    = o_v & o_r;
        // Words outstanding once this cycle's pop retires; pop implies
        // buf_cnt_q >= 1 so this never underflows.
        occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == StBusy) && (issue_rem_q != '0) && (occ_after_pop < 3'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            issue_rem_q   <= '0;
            deliver_rem_q <= '0;
            inflight_q    <= 1'b0;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            buf_cnt_q     <= 2'd0;
        end else begin
            inflight_q <= issue;

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q        <= i_addr;
                        issue_rem_q   <= i_cnt;
                        deliver_rem_q <= i_cnt;
                        // An empty burst never leaves idle.
                        if (i_cnt != '0) begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (issue) begin
                        addr_q      <= addr_q + addr_width'(1);
                        issue_rem_q <= issue_rem_q - cnt_width'(1);
                    end
                    if (pop) begin
                        deliver_rem_q <= deliver_rem_q - cnt_width'(1);
                        if (deliver_rem_q == cnt_width'(1)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Data returns one cycle after issue, so inflight_q marks capture.
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= i_rd_rd;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({inflight_q, pop})
                2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
                2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
                default: buf_cnt_q <= buf_cnt_q;
            endcase
        end
    end

    always_comb begin
        i_r     = (state_q == StIdle);
        o_rd_re = issue;
        o_rd_ra = addr_q;
        o_v     = (buf_cnt_q != 2'd0);
        o_d     = buf_q[rd_ptr_q];
        o_last  = o_v && (deliver_rem_q == cnt_width'(1));
        o_idle  = (state_q == StIdle) && !inflight_q && (buf_cnt_q == 2'd0);
    end

endmodule

// File: doc/base_mem_rdstream.md
# base_mem_rdstream

Read-side sequencer for the team's simple dual-port RAM (registered read port, 1-cycle read latency). It accepts a burst command (start address, beat count), drives the RAM read port, and presents the returned words as a valid/ready stream with a last-beat marker. A 2-entry buffer absorbs the fixed RAM latency, so full throughput (1 beat/cycle) is sustained under continuous ready and no word is lost under backpressure.

## Interface
- width, 1, data word width; must match the RAM
- addr_width, 1, RAM address width
- cnt_width, 8, beat-count field width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_v  in  1  command valid
- i_r  out  1  command ready; high only when idle
- i_addr  in  addr_width  burst start address
- i_cnt  in  cnt_width  beat count (0 = empty burst)
- o_rd_re  out  1  RAM read enable
- o_rd_ra  out  addr_width  RAM read address
- i_rd_rd  in  width  RAM read data, valid the cycle after o_rd_re
- o_v  out  1  output beat valid
- o_r  in  1  output beat ready
- o_d  out  width  output data
- o_last  out  1  final beat of burst, qualified by o_v
- o_idle  out  1  no command active, nothing in flight or buffered

## Operation
- Command handshake: accepted on the edge where i_v & i_r. i_r = idle; only one burst active at a time.
- On accept: next-address register <= i_addr; remaining-to-issue <= i_cnt; remaining-to-deliver <= i_cnt.
- i_cnt = 0: burst accepted, no reads, no beats; block is idle again the cycle after accept.
- Issue rule (combinational): o_rd_re = active & issue_rem != 0 & (buf_cnt + inflight - pop) < 2, where pop = o_v & o_r and inflight = o_rd_re registered one cycle. o_rd_ra = next-address register.
- On each issue: address += 1 modulo 2^addr_width (wraps from all-ones to 0); issue_rem -= 1.
- Capture: when inflight is high, i_rd_rd is written into the 2-entry FIFO buffer. Buffer order = issue order.
- Output: o_v = buf_cnt != 0; o_d = buffer head. o_last = o_v & (deliver_rem == 1). On pop, deliver_rem -= 1 and the head advances.
- Simultaneous capture and pop with buf_cnt = 2 cannot occur (the issue rule bounds occupancy); with buf_cnt = 1, both occur and buf_cnt is unchanged.
- Burst completes on the pop with o_last; block returns to idle and i_r rises the next cycle.
- o_idle = !active & !inflight & buf_cnt == 0.
- Reset at any time: active, counters, inflight, and buffer are cleared. RAM data returning the cycle after reset is ignored because inflight was cleared.

## Timing
- Reset values: i_r = 1, o_rd_re = 0, o_rd_ra = 0, o_v = 0, o_d = 0, o_last = 0, o_idle = 1.
- Accept at edge E0. The first o_rd_re is in the cycle after E0. Data is captured at the end of the following cycle. The first o_v is 3 cycles after E0.
- With o_r held high, one beat per cycle and one read per cycle. An N-beat burst delivers its last beat N+2 cycles after E0. i_r rises in the cycle after the last pop.
- With o_r low, at most 2 words are outstanding (in-flight plus buffered). o_rd_re stays low until a pop frees a slot, then resumes the same cycle as the pop.
- o_d and o_last hold stable while o_v & !o_r.

## Test plan
- Single beat: i_addr = 5, i_cnt = 1, o_r = 1 -> one o_rd_re with ra = 5. o_v, o_last, o_d = mem[5] appear 3 cycles after accept. i_r returns high the cycle after the pop.
- Streaming: i_addr = 0x10, i_cnt = 8, o_r = 1 -> o_rd_re high 8 consecutive cycles (ra 0x10..0x17). 8 consecutive beats in order. o_last only on the 8th beat.
- Backpressure: i_cnt = 6, o_r toggling 1,0,0,1,0,1... -> never more than 2 outstanding. No word dropped or duplicated. o_d stable while stalled. Beats arrive in address order.
- Wrap: addr_width = 4, i_addr = 14, i_cnt = 4 -> ra sequence 14, 15, 0, 1. Data matches mem[14], mem[15], mem[0], mem[1].
- Zero count: i_cnt = 0 -> no o_rd_re and no o_v. i_r high again 1 cycle after accept. A following 1-beat command works normally.
- Reset mid-burst: assert reset with 1 word in flight and 1 buffered -> all outputs immediately take their reset values. The read data returning the next cycle is not captured. A new command after reset delivers only its own data.
